// File: rtl/iq_mixer_4ch.sv
// rtl/iq_mixer_4ch.sv - 4-channel I/Q mixer with windowed integration and squared-magnitude dump.
// Optional IQMIX_DC_BLOCK_EN mixes the first difference of the sample stream instead of the raw sample.
module iq_mixer_4ch #(
  parameter int SAMPLE_W = 16,
  parameter int NCO_W    = 18,
  parameter int ACC_W    = 48,
  parameter int LOG2_WIN = 7,
  parameter int SCALE_SH = 24
) (
  input  logic               CK,
  input  logic               RST,
  input  logic               SAMPLE_VALID,
  input  logic [SAMPLE_W-1:0] sample,
  input  logic [NCO_W-1:0]   cos0,
  input  logic [NCO_W-1:0]   sin0,
  input  logic [NCO_W-1:0]   cos1,
  input  logic [NCO_W-1:0]   sin1,
  input  logic [NCO_W-1:0]   cos2,
  input  logic [NCO_W-1:0]   sin2,
  input  logic [NCO_W-1:0]   cos3,
  input  logic [NCO_W-1:0]   sin3,
  output logic               BUSY,
  output logic               OVERRUN,
  output logic               OUT_VALID,
  output logic [1:0]         OUT_CH,
  output logic [2*NCO_W:0]   OUT_MAG,
  output logic               FRAME_END
);

`ifdef IQMIX_DC_BLOCK_EN
  localparam int XW = SAMPLE_W + 1;
`else
  localparam int XW = SAMPLE_W;
`endif
  localparam int MW = (XW > NCO_W) ? XW : NCO_W;
  localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (NCO_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {IDLE, MAC, DUMP} state_t;

  state_t                    state;
  logic [2:0]                k;
  logic [LOG2_WIN-1:0]       cnt;
  logic signed [XW-1:0]      x_lat;
  logic signed [NCO_W-1:0]   nco_lat [8];
  logic signed [ACC_W-1:0]   acc [8];
  logic [2*NCO_W-1:0]        mag_part;

  logic signed [XW-1:0]      x_new;
  logic signed [ACC_W-1:0]   acc_sh;
  logic signed [NCO_W-1:0]   sat;
  logic signed [MW-1:0]      op_a;
  logic signed [MW-1:0]      op_b;
  logic signed [2*MW-1:0]    prod;

`ifdef IQMIX_DC_BLOCK_EN
  logic signed [SAMPLE_W-1:0] x_prev;
  assign x_new = $signed({sample[SAMPLE_W-1], sample}) - $signed({x_prev[SAMPLE_W-1], x_prev});
`else
  assign x_new = $signed(sample);
`endif

  // The single multiplier: x * nco during MAC, sat * sat during DUMP.
  always_comb begin
    acc_sh = acc[k] >>> SCALE_SH;
    if (acc_sh > SAT_MAX)
      sat = {1'b0, {(NCO_W-1){1'b1}}};
    else if (acc_sh < SAT_MIN)
      sat = {1'b1, {(NCO_W-1){1'b0}}};
    else
      sat = acc_sh[NCO_W-1:0];
    if (state == DUMP) begin
      op_a = MW'(sat);
      op_b = MW'(sat);
    end else begin
      op_a = MW'(x_lat);
      op_b = MW'(nco_lat[k]);
    end
    prod = op_a * op_b;
  end

  always_ff @(posedge CK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      x_lat     <= '0;
      mag_part  <= '0;
      BUSY      <= 1'b0;
      OVERRUN   <= 1'b0;
      OUT_VALID <= 1'b0;
      OUT_CH    <= '0;
      OUT_MAG   <= '0;
      FRAME_END <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        nco_lat[i] <= '0;
        acc[i]     <= '0;
      end
`ifdef IQMIX_DC_BLOCK_EN
      x_prev    <= '0;
`endif
    end else begin
      OUT_VALID <= 1'b0;
      FRAME_END <= 1'b0;
      if (SAMPLE_VALID && state != IDLE)
        OVERRUN <= 1'b1;
      case (state)
        IDLE: begin
          if (SAMPLE_VALID) begin
            x_lat      <= x_new;
            nco_lat[0] <= cos0;
            nco_lat[1] <= sin0;
            nco_lat[2] <= cos1;
            nco_lat[3] <= sin1;
            nco_lat[4] <= cos2;
            nco_lat[5] <= sin2;
            nco_lat[6] <= cos3;
            nco_lat[7] <= sin3;
`ifdef IQMIX_DC_BLOCK_EN
            x_prev     <= sample;
`endif
            k     <= '0;
            state <= MAC;
            BUSY  <= 1'b1;
          end
        end
        MAC: begin
          acc[k] <= acc[k] + ACC_W'(prod);
          k      <= k + 3'd1;
          if (k == 3'd7) begin
            cnt <= cnt + 1'b1;
            // k wraps to 0 here, so DUMP starts on channel 0's I accumulator.
            if (&cnt) begin
              state <= DUMP;
            end else begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        DUMP: begin
          acc[k] <= '0;
          k      <= k + 3'd1;
          if (!k[0]) begin
            mag_part <= prod[2*NCO_W-1:0];
          end else begin
            OUT_MAG   <= {1'b0, mag_part} + {1'b0, prod[2*NCO_W-1:0]};
            OUT_CH    <= k[2:1];
            OUT_VALID <= 1'b1;
            FRAME_END <= (k == 3'd7);
            if (k == 3'd7) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule
